// File: rtl/wdt_window.sv
// -----------------------------------------------------------------------------
// wdt_window -- parametrised windowed watchdog
//
// A down-counter watchdog with an early-kick window, a pre-timeout warning,
// a stretched reset request, fault-cause reporting and a saturating fault
// counter. wdt_reset is intended to drive the reset request input of the
// system reset controller.
//
// Build option:
//   WDT_WINDOW_EN  defined   : a kick while count > WIN_OPEN is an early-kick
//                              fault (fault_cause = 2'b10).
//                  undefined : every kick while running reloads the counter;
//                              WIN_OPEN is only range-checked.
//
// Parameters:
//   CNT_W        down-counter width (TIMEOUT must fit in CNT_W bits)
//   TIMEOUT      reload value; the counter runs TIMEOUT..0
//   WIN_OPEN     a kick is legal only when count <= WIN_OPEN
//   WARN_THRESH  warn is high while running with count <= WARN_THRESH
//   RST_PULSE    wdt_reset high time in cycles (1..255)
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   enable       level, 1 = watchdog armed
//   kick         service request, sampled every rising edge
//   wdt_reset    registered reset request, RST_PULSE cycles per fault
//   warn         registered pre-timeout warning
//   fault_cause  00 none, 01 timeout, 10 early kick (holds the last fault)
//   timeout_cnt  saturating count of faults (timeouts + early kicks)
//   count        current counter value
// -----------------------------------------------------------------------------
module wdt_window #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int WIN_OPEN    = 500,
    parameter int WARN_THRESH = 100,
    parameter int RST_PULSE   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             kick,
    output logic             wdt_reset,
    output logic             warn,
    output logic [1:0]       fault_cause,
    output logic [7:0]       timeout_cnt,
    output logic [CNT_W-1:0] count
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // -------------------------------------------------------------------------
    generate
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("wdt_window: CNT_W must be in 1..32");
        end
        if (TIMEOUT < 1 || longint'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
            $error("wdt_window: TIMEOUT must be >= 1 and < 2**CNT_W");
        end
        if (WIN_OPEN < 0 || WIN_OPEN > TIMEOUT) begin : g_bad_win_open
            $error("wdt_window: WIN_OPEN must be in 0..TIMEOUT");
        end
        if (WARN_THRESH < 0 || WARN_THRESH >= TIMEOUT) begin : g_bad_warn
            $error("wdt_window: WARN_THRESH must be in 0..TIMEOUT-1");
        end
        if (RST_PULSE < 1 || RST_PULSE > 255) begin : g_bad_pulse
            $error("wdt_window: RST_PULSE must be in 1..255");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WARN_C    = CNT_W'(WARN_THRESH);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = '0;

    // The pulse counter holds the number of HOLD edges still to come before
    // the release edge, so it is loaded with RST_PULSE-1 on fault entry.
    localparam logic [7:0] PULSE_LAST_C = 8'(RST_PULSE - 1);

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_EARLY   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t     state_reg;
    logic [7:0] pulse_cnt_reg;

    // -------------------------------------------------------------------------
    // Kick classification
    // -------------------------------------------------------------------------
    logic early_kick;

`ifdef WDT_WINDOW_EN
    localparam logic [CNT_W-1:0] WIN_OPEN_C = CNT_W'(WIN_OPEN);
    // A kick while the counter is still above the window is a fault.
    assign early_kick = kick && (count > WIN_OPEN_C);
`else
    // Without the window every kick while running is a legal service.
    assign early_kick = 1'b0;
`endif

    // Fault counter increment that sticks at 255 instead of wrapping.
    logic [7:0] timeout_cnt_sat;
    assign timeout_cnt_sat = (timeout_cnt == 8'hFF) ? 8'hFF : (timeout_cnt + 8'd1);

    // Value the counter takes on a plain decrement; only used when count != 0.
    logic [CNT_W-1:0] count_dec;
    assign count_dec = count - ONE_C;

    // -------------------------------------------------------------------------
    // Watchdog state machine; every output is a register written here
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            count         <= TIMEOUT_C;
            wdt_reset     <= 1'b0;
            warn          <= 1'b0;
            fault_cause   <= CAUSE_NONE;
            timeout_cnt   <= 8'd0;
            pulse_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Counter parked at the reload value; kicks have no effect.
                    // Arming does not consume a count on the arming edge.
                    count     <= TIMEOUT_C;
                    warn      <= 1'b0;
                    wdt_reset <= 1'b0;
                    if (enable) begin
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!enable) begin
                        state_reg <= ST_IDLE;
                        count     <= TIMEOUT_C;
                        warn      <= 1'b0;
                    end else if (early_kick) begin
                        state_reg     <= ST_HOLD;
                        count         <= TIMEOUT_C;
                        warn          <= 1'b0;
                        wdt_reset     <= 1'b1;
                        fault_cause   <= CAUSE_EARLY;
                        timeout_cnt   <= timeout_cnt_sat;
                        pulse_cnt_reg <= PULSE_LAST_C;
                    end else if (kick) begin
                        // Legal service, including a kick on the terminal count.
                        count <= TIMEOUT_C;
                        warn  <= 1'b0;
                    end else if (count == ZERO_C) begin
                        state_reg     <= ST_HOLD;
                        count         <= TIMEOUT_C;
                        warn          <= 1'b0;
                        wdt_reset     <= 1'b1;
                        fault_cause   <= CAUSE_TIMEOUT;
                        timeout_cnt   <= timeout_cnt_sat;
                        pulse_cnt_reg <= PULSE_LAST_C;
                    end else begin
                        // warn follows the value the counter is about to take.
                        count <= count_dec;
                        warn  <= (count_dec <= WARN_C);
                    end
                end

                ST_HOLD: begin
                    // The pulse always runs to completion: enable is only
                    // looked at on the release edge and kick is ignored.
                    count <= TIMEOUT_C;
                    warn  <= 1'b0;
                    if (pulse_cnt_reg == 8'd0) begin
                        wdt_reset <= 1'b0;
                        state_reg <= enable ? ST_RUN : ST_IDLE;
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg - 8'd1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    count     <= TIMEOUT_C;
                    warn      <= 1'b0;
                    wdt_reset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wdt_window.sv
// -----------------------------------------------------------------------------
// tb_wdt_window -- self-checking bench for wdt_window
//
// Every edge is mirrored by a small behavioural model that tracks "armed",
// "remaining pulse cycles", the counter value and the fault history with
// plain integers. Each scenario task compares the DUT outputs against that
// model after every edge and adds targeted checks for the scenario.
// -----------------------------------------------------------------------------
module tb_wdt_window;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 20;
    localparam int WIN_OPEN    = 10;
    localparam int WARN_THRESH = 4;
    localparam int RST_PULSE   = 3;

`ifdef WDT_WINDOW_EN
    localparam bit WINDOWED = 1'b1;
`else
    localparam bit WINDOWED = 1'b0;
`endif

    logic             clock  = 1'b0;
    logic             reset  = 1'b0;
    logic             enable = 1'b0;
    logic             kick   = 1'b0;
    logic             wdt_reset;
    logic             warn;
    logic [1:0]       fault_cause;
    logic [7:0]       timeout_cnt;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;

    wdt_window #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .WIN_OPEN   (WIN_OPEN),
        .WARN_THRESH(WARN_THRESH),
        .RST_PULSE  (RST_PULSE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .kick       (kick),
        .wdt_reset  (wdt_reset),
        .warn       (warn),
        .fault_cause(fault_cause),
        .timeout_cnt(timeout_cnt),
        .count      (count)
    );

    always #5 clock = ~clock;

    logic [27:0] act_vec;
    assign act_vec = {wdt_reset, warn, fault_cause, timeout_cnt, count};

    // ---------------------------------------------------------------- model
    int m_cnt;
    int m_hold_left;   // pulse cycles still to show, 0 = no pulse in progress
    int m_fault;
    int m_faults;
    bit m_running;

    task automatic model_reset();
        m_cnt       = TIMEOUT;
        m_hold_left = 0;
        m_fault     = 0;
        m_faults    = 0;
        m_running   = 1'b0;
    endtask

    task automatic model_fault(input int cause);
        m_hold_left = RST_PULSE;
        m_fault     = cause;
        m_faults    = (m_faults < 255) ? m_faults + 1 : 255;
        m_cnt       = TIMEOUT;
    endtask

    task automatic model_step(input bit en, input bit k);
        if (m_hold_left > 0) begin
            m_hold_left = m_hold_left - 1;
            if (m_hold_left == 0) m_running = en;
            m_cnt = TIMEOUT;
        end else if (!m_running) begin
            m_running = en;
            m_cnt     = TIMEOUT;
        end else if (!en) begin
            m_running = 1'b0;
            m_cnt     = TIMEOUT;
        end else if (k && WINDOWED && m_cnt > WIN_OPEN) begin
            model_fault(2);
        end else if (k) begin
            m_cnt = TIMEOUT;
        end else if (m_cnt == 0) begin
            model_fault(1);
        end else begin
            m_cnt = m_cnt - 1;
        end
    endtask

    function automatic logic [27:0] exp_vec();
        logic r;
        logic w;
        r = (m_hold_left > 0);
        w = (m_hold_left == 0) && m_running && (m_cnt <= WARN_THRESH);
        return {r, w, 2'(m_fault), 8'(m_faults), 16'(m_cnt)};
    endfunction

    // One clock edge: drive inputs, advance the model, sample 1 ns later.
    task automatic tick(input bit en, input bit k);
        enable = en;
        kick   = k;
        @(posedge clock);
        model_step(en, k);
        #1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        model_reset();
        #12;
        total++;
        if (act_vec !== {1'b0, 1'b0, 2'b00, 8'd0, 16'd20}) begin
            bad++;
            $display("FAIL reset_values: got %h want %h", act_vec, {1'b0, 1'b0, 2'b00, 8'd0, 16'd20});
        end
        #8 reset = 1'b1;
        // Disarmed: the counter stays parked and kicks do nothing.
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, i[0]);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL idle edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        $display("test_reset done: total=%0d", total);
    endtask

    task automatic test_timeout();
        int rise = 0;
        int width = 0;
        int warn_rise = 0;
        tick(1'b1, 1'b0);  // arming edge
        total++;
        if (count !== 16'd20) begin
            bad++;
            $display("FAIL arm_edge_count: got %0d want 20", count);
        end
        for (int e = 1; e <= 30; e++) begin
            tick(1'b1, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL timeout_seq edge %0d: got %h want %h", e, act_vec, exp_vec());
            end
            if (wdt_reset && rise == 0) rise = e;
            if (wdt_reset) width++;
            if (warn && warn_rise == 0) warn_rise = e;
        end
        total++;
        if (rise != 21) begin
            bad++;
            $display("FAIL timeout_rise_edge: got %0d want 21", rise);
        end
        total++;
        if (width != 3) begin
            bad++;
            $display("FAIL timeout_pulse_width: got %0d want 3", width);
        end
        total++;
        if (warn_rise != 16) begin
            bad++;
            $display("FAIL warn_rise_edge: got %0d want 16", warn_rise);
        end
        total++;
        if (fault_cause !== 2'b01 || timeout_cnt !== 8'd1) begin
            bad++;
            $display("FAIL timeout_cause: got cause=%b cnt=%0d want cause=01 cnt=1", fault_cause, timeout_cnt);
        end
        $display("test_timeout done: rise=%0d width=%0d warn_rise=%0d", rise, width, warn_rise);
    endtask

    task automatic test_legal_kick();
        bit seen_rst = 1'b0;
        for (int i = 0; i < 40 && m_cnt != 8; i++) begin
            tick(1'b1, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL legal_pre edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        tick(1'b1, 1'b1);
        total++;
        if (count !== 16'd20 || warn !== 1'b0 || wdt_reset !== 1'b0) begin
            bad++;
            $display("FAIL legal_kick_at_8: got count=%0d warn=%b rst=%b want 20/0/0", count, warn, wdt_reset);
        end
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, (i % 12) == 11);
            if (wdt_reset) seen_rst = 1'b1;
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL legal_loop edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        total++;
        if (seen_rst !== 1'b0) begin
            bad++;
            $display("FAIL legal_loop_no_reset: got reset seen=%b want 0", seen_rst);
        end
        $display("test_legal_kick done: count=%0d", count);
    endtask

    task automatic test_early_kick();
        logic [1:0] want_cause;
        tick(1'b0, 1'b0);  // disarm
        tick(1'b1, 1'b0);  // re-arm at 20
        for (int i = 0; i < 40 && m_cnt != 15; i++) tick(1'b1, 1'b0);
        want_cause = WINDOWED ? 2'b10 : fault_cause;
        tick(1'b1, 1'b1);
        total++;
        if (wdt_reset !== WINDOWED || fault_cause !== want_cause || count !== 16'd20) begin
            bad++;
            $display("FAIL early_kick_at_15: got rst=%b cause=%b count=%0d want rst=%b cause=%b count=20",
                     wdt_reset, fault_cause, count, WINDOWED, want_cause);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL early_after edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        $display("test_early_kick done: windowed=%0d cause=%b", WINDOWED, fault_cause);
    endtask

    task automatic test_kick_zero();
        for (int i = 0; i < 10 && m_hold_left > 0; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 40 && m_cnt != 0; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        total++;
        if (count !== 16'd20 || wdt_reset !== 1'b0) begin
            bad++;
            $display("FAIL kick_at_zero: got count=%0d rst=%b want 20/0", count, wdt_reset);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL kick_zero_after edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        $display("test_kick_zero done: count=%0d", count);
    endtask

    task automatic test_hold_kick();
        int width = 1;
        for (int i = 0; i < 40 && m_hold_left == 0; i++) tick(1'b1, 1'b0);
        total++;
        if (wdt_reset !== 1'b1) begin
            bad++;
            $display("FAIL hold_kick_entry: got rst=%b want 1", wdt_reset);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL hold_kick edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
            if (!wdt_reset) break;
            width++;
        end
        total++;
        if (width != 3) begin
            bad++;
            $display("FAIL hold_kick_width: got %0d want 3", width);
        end
        $display("test_hold_kick done: width=%0d", width);
    endtask

    task automatic test_hold_disable();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 40 && m_hold_left == 0; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL hold_disable edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        total++;
        if (count !== 16'd20 || wdt_reset !== 1'b0 || warn !== 1'b0) begin
            bad++;
            $display("FAIL hold_disable_idle: got count=%0d rst=%b warn=%b want 20/0/0", count, wdt_reset, warn);
        end
        $display("test_hold_disable done: count=%0d", count);
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 40 && m_hold_left == 0; i++) tick(1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (wdt_reset !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_hold_rst: got %b want 0", wdt_reset);
        end
        total++;
        if (timeout_cnt !== 8'd0 || fault_cause !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_hold_status: got cnt=%0d cause=%b want 0/00", timeout_cnt, fault_cause);
        end
        total++;
        if (count !== 16'd20 || warn !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_hold_count: got count=%0d warn=%b want 20/0", count, warn);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL after_mid_reset edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        $display("test_reset_mid_hold done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 19) != 0, $urandom_range(0, 5) == 0);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        $display("test_random done: faults=%0d", timeout_cnt);
    endtask

    task automatic test_saturate();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        // One fault per 24 edges with no kicks; run past 256 faults.
        for (int i = 0; i < 258 * 24 + 10; i++) begin
            tick(1'b1, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL saturate edge %0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        total++;
        if (timeout_cnt !== 8'd255) begin
            bad++;
            $display("FAIL saturate_final: got %0d want 255", timeout_cnt);
        end
        $display("test_saturate done: timeout_cnt=%0d", timeout_cnt);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_legal_kick();
        test_early_kick();
        test_kick_zero();
        test_hold_kick();
        test_hold_disable();
        test_reset_mid_hold();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish want finish before 2 ms");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/wdt_window.md
Name: wdt_window

Overview:
Parametrised windowed watchdog; next generation of the single-kick down-counter watchdog. It adds a configurable count width and timeout, an early-kick window, a pre-timeout warning, a stretched reset pulse, fault-cause reporting and a saturating timeout counter. It sits beside the system reset controller; wdt_reset drives the controller's reset request input.

Parameters:
CNT_W, 16, down-counter width; TIMEOUT must be < 2^CNT_W.
TIMEOUT, 1000, reload value; counter runs TIMEOUT..0.
WIN_OPEN, 500, kick legal only when count <= WIN_OPEN (0 <= WIN_OPEN <= TIMEOUT).
WARN_THRESH, 100, warn asserted when count <= WARN_THRESH (WARN_THRESH < TIMEOUT).
RST_PULSE, 4, wdt_reset high time in cycles (>= 1, <= 255).

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous active-low reset.
enable  input  1  level; 1 = watchdog armed.
kick  input  1  service request, sampled each rising edge (level; one cycle high = one kick).
wdt_reset  output  1  registered reset request, high for exactly RST_PULSE cycles per fault.
warn  output  1  registered pre-timeout warning.
fault_cause  output  2  00 none, 01 timeout, 10 early kick; holds last fault.
timeout_cnt  output  8  saturating fault count (timeouts + early kicks).
count  output  CNT_W  current counter value.

Behaviour:
- reset low (async): state IDLE, count=TIMEOUT, wdt_reset=0, warn=0, fault_cause=00, timeout_cnt=0, pulse counter=0.
- States: IDLE, RUN, HOLD. All outputs are registered.
- IDLE: count held at TIMEOUT; kick ignored. Edge with enable=1 -> RUN; count stays TIMEOUT on that edge.
- RUN, each edge, priority order:
  1. enable=0 -> IDLE, count=TIMEOUT, warn=0.
  2. kick=1 and count > WIN_OPEN (early): -> HOLD, wdt_reset=1, fault_cause=10, timeout_cnt+1 (saturate at 255).
  3. kick=1 and count <= WIN_OPEN (legal, including count==0): count=TIMEOUT, warn=0; stays RUN.
  4. count==0, no kick: -> HOLD, wdt_reset=1, fault_cause=01, timeout_cnt+1 (saturate).
  5. Otherwise count=count-1.
- warn: registered from the next count value; 1 iff state is RUN and next count <= WARN_THRESH.
- Timing: the first edge after entering RUN with no kick produces count=TIMEOUT-1. wdt_reset rises on edge TIMEOUT+1 after the RUN-entry edge.
- HOLD: wdt_reset=1 for exactly RST_PULSE cycles; kick and enable are ignored, and the pulse is never truncated. warn=0, count=TIMEOUT. At the end of the pulse: enable=1 -> RUN (fresh TIMEOUT), enable=0 -> IDLE; wdt_reset=0 on that edge.
- fault_cause and timeout_cnt are cleared only by reset. Neither enable nor the block's own wdt_reset clears them.
- reset asserted mid-HOLD: wdt_reset drops immediately (async); all state returns to reset values.
- Count arithmetic is unsigned CNT_W and never underflows; 0 is the terminal value.

Optional Feature:
Macro WDT_WINDOW_EN.
- Defined: early-kick rule (RUN item 2) is active as above.
- Not defined: every kick in RUN is legal regardless of count; WIN_OPEN is unused; fault_cause never reports 10.

Test Plan:
Parameters TIMEOUT=20, WIN_OPEN=10, WARN_THRESH=4, RST_PULSE=3, 10 ns clock.
- Reset low 20 ns, then high; enable=1, no kick -> count 20..0; warn rises when count=4; wdt_reset rises 21 edges after RUN entry, high exactly 3 cycles; fault_cause=01, timeout_cnt=1; count restarts at 20.
- Legal kick one cycle at count=8 -> count=20 next edge, warn stays 0; repeat kicks every 12 cycles for 200 cycles -> wdt_reset never asserts.
- Kick at count=15 (WDT_WINDOW_EN defined) -> wdt_reset high 3 cycles, fault_cause=10; same stimulus with the macro undefined -> count reloads to 20, no reset.
- Kick coincident with count=0 -> reload to 20, no wdt_reset. Kick during HOLD -> ignored, pulse stays 3 cycles. enable=0 during HOLD -> IDLE after the pulse, count=20.
- Drive reset low mid-HOLD -> wdt_reset=0 within the same cycle, timeout_cnt=0, fault_cause=00. Force 256 timeouts -> timeout_cnt saturates at 255.
